// File: rtl/axis_dp_pkt_mux.sv
// axis_dp_pkt_mux: packet-atomic AXI-Stream S_COUNT:1 multiplexer.
// A select token (index + drop flag) is taken in IDLE and names the source of the
// next packet. That packet then goes through a registered output stage beat by beat,
// or it is consumed and discarded. The mux does not take another token until tlast
// is accepted, so each packet is followed by one idle bubble.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s_sel_valid/ready         select token handshake
//   s_sel_index, s_sel_drop   source index for the next packet, discard flag
//   s_axis_t*                 S_COUNT packed input streams (tdata/tkeep/tvalid/
//                             tready/tlast/tid/tdest/tuser)
//   m_axis_t*                 registered output stream
//   busy                      high while a packet is being forwarded or dropped
//   stat_pkt_fwd/drop         packet counters, present only with the
//                             AXIS_DP_MUX_STATS_EN macro defined
//
// Configuration: define AXIS_DP_MUX_STATS_EN to add the two 32-bit packet counters.
// The counters wrap. Without the macro the ports and counters are absent, and the
// datapath behaves the same.

module axis_dp_pkt_mux #(
  parameter int unsigned S_COUNT    = 2,
  parameter int unsigned SEL_WIDTH  = $clog2(S_COUNT),
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 9,
  parameter int unsigned USER_WIDTH = 97
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            s_sel_valid,
  output logic                            s_sel_ready,
  input  logic [SEL_WIDTH-1:0]            s_sel_index,
  input  logic                            s_sel_drop,

  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]     s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,

  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic [DEST_WIDTH-1:0]           m_axis_tdest,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,

  output logic                            busy
`ifdef AXIS_DP_MUX_STATS_EN
  ,
  output logic [31:0]                     stat_pkt_fwd,
  output logic [31:0]                     stat_pkt_drop
`endif
);

  localparam int unsigned STAT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t                 state;
  logic [SEL_WIDTH-1:0]   sel_idx;

  // Source mux outputs for the latched index
  logic [S_COUNT-1:0]     sel_hit;
  logic                   sel_in_range;
  logic                   sel_tvalid;
  logic                   sel_tlast;
  logic [DATA_WIDTH-1:0]  sel_tdata;
  logic [KEEP_WIDTH-1:0]  sel_tkeep;
  logic [ID_WIDTH-1:0]    sel_tid;
  logic [DEST_WIDTH-1:0]  sel_tdest;
  logic [USER_WIDTH-1:0]  sel_tuser;

  logic                   out_stall;
  logic                   beat_acc;
  logic                   token_in_range;

  // Select the latched source. An out-of-range index matches no source, so
  // sel_hit stays all-zero and no upstream ready is ever raised for it.
  always_comb begin
    sel_hit   = '0;
    sel_tvalid = 1'b0;
    sel_tlast = 1'b0;
    sel_tdata = '0;
    sel_tkeep = '0;
    sel_tid   = '0;
    sel_tdest = '0;
    sel_tuser = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (sel_idx == SEL_WIDTH'(i)) begin
        sel_hit[i] = 1'b1;
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tid    = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
        sel_tdest  = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        sel_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  assign sel_in_range   = (32'(sel_idx) < S_COUNT);
  assign token_in_range = (32'(s_sel_index) < S_COUNT);

  // The output register can take a new beat when it is empty or is being drained
  assign out_stall = m_axis_tvalid & ~m_axis_tready;

  // Upstream ready goes only to the selected source. It is forced low during
  // reset, so beats that are not consumed stay with their producer.
  always_comb begin
    s_axis_tready = '0;
    if (!rst) begin
      unique case (state)
        FORWARD: if (!out_stall) s_axis_tready = sel_hit;
        DROP:    s_axis_tready = sel_hit;
        default: s_axis_tready = '0;
      endcase
    end
  end

  assign beat_acc    = sel_tvalid & |(s_axis_tready & sel_hit);
  assign s_sel_ready = (state == IDLE) & ~rst;
  assign busy        = (state != IDLE);

  // Packet FSM, output register and optional packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_idx       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
`ifdef AXIS_DP_MUX_STATS_EN
      stat_pkt_fwd  <= '0;
      stat_pkt_drop <= '0;
`endif
    end else begin
      // Consumed beat empties the register unless a new one is loaded below
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (s_sel_valid) begin
            sel_idx <= s_sel_index;
            state   <= (s_sel_drop || !token_in_range) ? DROP : FORWARD;
          end
        end

        FORWARD: begin
          if (beat_acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_tlast;
            m_axis_tdata  <= sel_tdata;
            m_axis_tkeep  <= sel_tkeep;
            m_axis_tid    <= sel_tid;
            m_axis_tdest  <= sel_tdest;
            m_axis_tuser  <= sel_tuser;
            if (sel_tlast) begin
              state <= IDLE;
`ifdef AXIS_DP_MUX_STATS_EN
              stat_pkt_fwd <= stat_pkt_fwd + STAT_WIDTH'(1);
`endif
            end
          end
        end

        DROP: begin
          // An out-of-range token has no source that could end the packet
          if (!sel_in_range) begin
            state <= IDLE;
          end else if (beat_acc && sel_tlast) begin
            state <= IDLE;
`ifdef AXIS_DP_MUX_STATS_EN
            stat_pkt_drop <= stat_pkt_drop + STAT_WIDTH'(1);
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dp_pkt_mux.sv
// Scoreboard bench for axis_dp_pkt_mux configured with three sources.
module tb_axis_dp_pkt_mux;

  localparam int unsigned S   = 3;
  localparam int unsigned SW  = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = 8;
  localparam int unsigned IW  = 1;
  localparam int unsigned DSW = 9;
  localparam int unsigned UW  = 97;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_sel_valid = 1'b0;
  logic              s_sel_ready;
  logic [SW-1:0]     s_sel_index = '0;
  logic              s_sel_drop = 1'b0;
  logic [S*DW-1:0]   s_axis_tdata = '0;
  logic [S*KW-1:0]   s_axis_tkeep = '0;
  logic [S-1:0]      s_axis_tvalid = '0;
  logic [S-1:0]      s_axis_tready;
  logic [S-1:0]      s_axis_tlast = '0;
  logic [S*IW-1:0]   s_axis_tid = '0;
  logic [S*DSW-1:0]  s_axis_tdest = '0;
  logic [S*UW-1:0]   s_axis_tuser = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [IW-1:0]     m_axis_tid;
  logic [DSW-1:0]    m_axis_tdest;
  logic [UW-1:0]     m_axis_tuser;
  logic              busy;
`ifdef AXIS_DP_MUX_STATS_EN
  logic [31:0]       stat_pkt_fwd;
  logic [31:0]       stat_pkt_drop;
`endif

  axis_dp_pkt_mux #(
    .S_COUNT(S), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_sel_valid(s_sel_valid), .s_sel_ready(s_sel_ready),
    .s_sel_index(s_sel_index), .s_sel_drop(s_sel_drop),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .busy(busy)
`ifdef AXIS_DP_MUX_STATS_EN
    , .stat_pkt_fwd(stat_pkt_fwd), .stat_pkt_drop(stat_pkt_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;  // 0: sink stalls, 1: always ready, 2: toggles every cycle

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic beat_t mk_beat(input int src, input logic [7:0] tag, input int b,
                                    input logic last);
    beat_t r;
    r.data = {tag, 8'(src), 16'(b), 32'hC0DE_0000 + 32'(b)};
    r.keep = last ? 8'h0F : 8'hFF;
    r.id   = IW'(b);
    r.dest = {1'b0, tag} + 9'(b);
    r.user = {tag, 89'(b * 7 + 1)};
    r.last = last;
    return r;
  endfunction

  task automatic present(input int src, input beat_t bt);
    s_axis_tdata[src*DW +: DW]   = bt.data;
    s_axis_tkeep[src*KW +: KW]   = bt.keep;
    s_axis_tid[src*IW +: IW]     = bt.id;
    s_axis_tdest[src*DSW +: DSW] = bt.dest;
    s_axis_tuser[src*UW +: UW]   = bt.user;
    s_axis_tlast[src]            = bt.last;
    s_axis_tvalid[src]           = 1'b1;
  endtask

  // Sink ready pattern, applied shortly after each rising edge
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ~m_axis_tready;
    endcase
  end

  // Monitor: pops expected beats on output transfers and checks that a stalled beat holds
  beat_t cur_beat, prev_beat, exp_beat;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    cur_beat = '{data: m_axis_tdata, keep: m_axis_tkeep, id: m_axis_tid,
                 dest: m_axis_tdest, user: m_axis_tuser, last: m_axis_tlast};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (cur_beat !== prev_beat || !m_axis_tvalid) begin
          errors++;
          $display("FAIL stall_hold actual data=%0h valid=%0b required data=%0h valid=1",
                   m_axis_tdata, m_axis_tvalid, prev_beat.data);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual data=%0h required no beat", m_axis_tdata);
        end else begin
          exp_beat = exp_q.pop_front();
          if (cur_beat !== exp_beat) begin
            errors++;
            $display("FAIL out_beat actual data=%0h keep=%0h last=%0b dest=%0h user=%0h required data=%0h keep=%0h last=%0b dest=%0h user=%0h",
                     cur_beat.data, cur_beat.keep, cur_beat.last, cur_beat.dest, cur_beat.user,
                     exp_beat.data, exp_beat.keep, exp_beat.last, exp_beat.dest, exp_beat.user);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur_beat;
    end
  end

  // Sends one token and one packet. Called and returns just after a rising edge.
  task automatic send_pkt(input int src, input int n, input logic [7:0] tag, input logic drop);
    int         t;
    beat_t      bt;
    logic       pend;
    logic [DW-1:0] pend_data;
    logic [S-1:0]  others;
    others      = '1;
    others[src] = 1'b0;
    pend        = 1'b0;
    pend_data   = '0;
    s_sel_valid = 1'b1;
    s_sel_index = SW'(src);
    s_sel_drop  = drop;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_sel_ready && t < 100);
    chk("sel_ready_wait", 128'(s_sel_ready), 128'(1));
    @(posedge clk); #1;
    s_sel_valid = 1'b0;
    for (int b = 0; b < n; b++) begin
      bt = mk_beat(src, tag, b, b == n - 1);
      present(src, bt);
      t = 0;
      do begin
        @(negedge clk);
        t++;
        if (pend && t == 1) begin
          chk("latency_valid", 128'(m_axis_tvalid), 128'(1));
          chk("latency_data", 128'(m_axis_tdata), 128'(pend_data));
        end
      end while (!s_axis_tready[src] && t < 100);
      chk("src_ready", 128'(s_axis_tready[src]), 128'(1));
      chk("other_ready", 128'(s_axis_tready & others), 128'(0));
      if (drop) begin
        chk("drop_no_out", 128'(m_axis_tvalid), 128'(0));
        chk("drop_ready_cycles", 128'(t), 128'(1));
      end else begin
        exp_q.push_back(bt);
      end
      pend      = !drop;
      pend_data = bt.data;
      @(posedge clk); #1;
    end
    s_axis_tvalid[src] = 1'b0;
    s_axis_tlast[src]  = 1'b0;
    @(negedge clk);
    if (pend) begin
      chk("latency_valid_last", 128'(m_axis_tvalid), 128'(1));
      chk("latency_data_last", 128'(m_axis_tdata), 128'(pend_data));
    end
    chk("busy_after_pkt", 128'(busy), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel_ready", 128'(s_sel_ready), 128'(0));
    chk("rst_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_m_tlast", 128'(m_axis_tlast), 128'(0));
    chk("rst_m_tdata", 128'(m_axis_tdata), 128'(0));
    chk("rst_m_tuser", 128'(m_axis_tuser), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_sel_ready", 128'(s_sel_ready), 128'(1));
    chk("idle_tready", 128'(s_axis_tready), 128'(0));
`ifdef AXIS_DP_MUX_STATS_EN
    chk("rst_stat_fwd", 128'(stat_pkt_fwd), 128'(0));
    chk("rst_stat_drop", 128'(stat_pkt_drop), 128'(0));
`endif
    @(posedge clk); #1;

    // 4-beat packet from source 1 with the sink always ready
    ready_mode = 1;
    send_pkt(1, 4, 8'h11, 1'b0);
    drain();

    // 3-beat packet on source 2 that is discarded
    send_pkt(2, 3, 8'h22, 1'b1);
`ifdef AXIS_DP_MUX_STATS_EN
    chk("stat_drop_1", 128'(stat_pkt_drop), 128'(1));
    chk("stat_fwd_1", 128'(stat_pkt_fwd), 128'(1));
`endif

    // 6-beat packet while the sink ready toggles every cycle
    ready_mode = 2;
    send_pkt(0, 6, 8'h33, 1'b0);
    drain();
    ready_mode = 1;
    @(posedge clk); #1;

    // Out-of-range index: no source ready, one busy cycle
    s_sel_valid = 1'b1;
    s_sel_index = 2'd3;
    s_sel_drop  = 1'b0;
    present(0, mk_beat(0, 8'h44, 0, 1'b1));
    present(1, mk_beat(1, 8'h44, 0, 1'b1));
    present(2, mk_beat(2, 8'h44, 0, 1'b1));
    @(negedge clk);
    chk("oor_sel_ready", 128'(s_sel_ready), 128'(1));
    @(posedge clk); #1;
    s_sel_valid = 1'b0;
    @(negedge clk);
    chk("oor_busy", 128'(busy), 128'(1));
    chk("oor_tready", 128'(s_axis_tready), 128'(0));
    chk("oor_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_back_idle", 128'(busy), 128'(0));
    chk("oor_sel_ready_again", 128'(s_sel_ready), 128'(1));
    @(posedge clk); #1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;

    // Packets back to back from different sources, one of them single-beat
    send_pkt(2, 2, 8'h55, 1'b0);
    send_pkt(0, 1, 8'h66, 1'b0);
    send_pkt(1, 3, 8'h77, 1'b0);
    drain();

    // Reset while beat 2 of 5 is pending and beat 1 is stalled in the output stage
    ready_mode = 0;
    @(posedge clk); #1;
    s_sel_valid = 1'b1;
    s_sel_index = 2'd0;
    s_sel_drop  = 1'b0;
    @(negedge clk);
    chk("mid_sel_ready", 128'(s_sel_ready), 128'(1));
    @(posedge clk); #1;
    s_sel_valid = 1'b0;
    present(0, mk_beat(0, 8'h88, 0, 1'b0));
    @(negedge clk);
    chk("mid_beat1_ready", 128'(s_axis_tready[0]), 128'(1));
    @(posedge clk); #1;
    present(0, mk_beat(0, 8'h88, 1, 1'b0));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tready", 128'(s_axis_tready), 128'(0));
    chk("mid_rst_sel_ready", 128'(s_sel_ready), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("mid_rst_m_tdata", 128'(m_axis_tdata), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sel_ready", 128'(s_sel_ready), 128'(1));
    chk("post_rst_tready", 128'(s_axis_tready), 128'(0));
    @(posedge clk); #1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    ready_mode = 1;
    @(posedge clk); #1;

    // Recovery after the abandoned packet
    send_pkt(0, 2, 8'h99, 1'b0);
    drain();
`ifdef AXIS_DP_MUX_STATS_EN
    chk("stat_fwd_after_rst", 128'(stat_pkt_fwd), 128'(1));
    chk("stat_drop_after_rst", 128'(stat_pkt_drop), 128'(0));
    force dut.stat_pkt_fwd = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.stat_pkt_fwd;
    send_pkt(2, 1, 8'hAA, 1'b0);
    drain();
    chk("stat_fwd_wrap", 128'(stat_pkt_fwd), 128'(0));
`endif

    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
